dff_resp_checker: RTL
=====================

Name: dff_resp_checker

Overview:
- Synthesizable response checker at the output end of the D flip-flop stimulus interface.
- Observes the DUT's d/rst inputs and its q/qbar outputs on the same clock.
- Keeps a golden one-flop model, compares every cycle and counts samples and mismatches.
- Holds a sticky error flag and captures the index of the first failing sample. Used in simulation benches and in on-chip self-check wrappers.

Parameters:
- CNT_W, 16, width of the sample and error counters and of the first-error index.
- NUM_SAMPLES, 10, compared samples before done asserts. 0 means unlimited, and done never asserts.
- STOP_ON_ERR, 0, when 1 the checker enters FAIL and freezes all counters on the first mismatch.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset of the checker.
- chk_en  input  1  level enable. Rising edge arms checking; low returns the checker to IDLE.
- dut_d  input  1  D value driven to the DUT.
- dut_rst  input  1  reset driven to the DUT. Active-high, synchronous clear of q in the golden model.
- dut_q  input  1  DUT q output.
- dut_qbar  input  1  DUT qbar output.
- err  output  1  sticky mismatch flag.
- err_cnt  output  CNT_W  mismatch count, saturating at all-ones.
- sample_cnt  output  CNT_W  number of compared samples, saturating.
- first_err_idx  output  CNT_W  sample_cnt value at the first mismatch.
- done  output  1  high once sample_cnt equals NUM_SAMPLES (NUM_SAMPLES > 0).
- state  output  2  current FSM state, for debug.

Behaviour:
- Reset (rst=0, asynchronous), all outputs 0:
  - state=IDLE, err=0, err_cnt=0, sample_cnt=0, first_err_idx=0, done=0.
  - Golden exp_q=0, exp_valid=0.
- Golden model, updated every posedge in any state:
  - exp_q <= dut_rst ? 0 : dut_d.
  - exp_valid <= 1 in ARM/CHECK, else 0.
- Compare rule at posedge N: dut_q sampled at N is compared with exp_q registered at N-1. This covers the one-cycle DUT latency.
- FSM encoding: IDLE=0, ARM=1, CHECK=2, FAIL=3.
  - IDLE: counters hold their values. On chk_en=1, clear err, err_cnt, sample_cnt, first_err_idx and done, then go to ARM.
  - ARM: exactly one cycle, loads the golden model, no compare. Goes to CHECK.
  - CHECK: each cycle, sample_cnt++ (saturating).
    - On a mismatch: err<=1 and err_cnt++ (saturating).
    - On the first mismatch: first_err_idx <= sample_cnt (pre-increment value).
    - If STOP_ON_ERR=1 and a mismatch occurs, go to FAIL.
    - When sample_cnt+1 == NUM_SAMPLES, done<=1 and comparison stops; the checker stays in CHECK with counters held.
  - FAIL: all outputs frozen until chk_en=0, then IDLE.
  - chk_en=0 in any state goes to IDLE next cycle; outputs are held for readout.
- Simultaneous events:
  - Mismatch on the final sample counts: err_cnt and done both update that cycle.
  - dut_rst=1 with dut_d=1 gives exp_q=0 (reset wins).
- Reset mid-CHECK: immediate return to the reset values above. No partial results are retained.
- Saturation: counters stop at 2^CNT_W-1 and never wrap.

Optional Feature:
- Macro: DFF_QBAR_CHECK_EN.
- Defined: a sample also mismatches when dut_qbar != ~dut_q. A q error and a qbar error in the same cycle count as one mismatch.
- Undefined: dut_qbar is ignored (port kept, unused) and only q is checked.

Decomposition:
- Package dff_chk_pkg holds:
  - the state typedef with the IDLE/ARM/CHECK/FAIL encodings;
  - the saturating-increment function;
  - the default CNT_W constant.
- One natural sub-module, dff_golden_model: the exp_q/exp_valid register pair. It is reusable by other flip-flop checkers.
- Counters and FSM stay in the top module.

Test Plan:
- Reset mid-run: rst=0 asserted asynchronously mid-CHECK -> all outputs 0 immediately, without waiting for a clock edge.
- Correct DUT: chk_en=1, NUM_SAMPLES=10, random dut_d, dut_q = d delayed one cycle -> done=1 after 11 cycles from arm, err=0, err_cnt=0, sample_cnt=10.
- Injected fault: dut_q forced inverted on compare sample 3 only -> err=1, err_cnt=1, first_err_idx=3, done=1.
- DUT reset: dut_rst=1 with dut_d=1 for 2 cycles and dut_q=0 -> no mismatch. dut_q=1 in that window -> err_cnt increments.
- STOP_ON_ERR=1: mismatches on samples 2 and 5 -> state=FAIL after sample 2, err_cnt=1, sample_cnt=3. chk_en=0 -> IDLE next cycle, values held.
- DFF_QBAR_CHECK_EN defined: correct q with dut_qbar=dut_q on sample 4 -> err_cnt=1, first_err_idx=4. With the macro undefined -> err_cnt=0.

Source files
------------

// File: rtl/dff_chk_pkg.sv
// Shared types and helpers for the D flip-flop response checker.
// The state encoding is visible on the debug port, so keep these values fixed.
package dff_chk_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_CHECK = 2'd2,
        ST_FAIL  = 2'd3
    } chk_state_t;

    // Increment that stops at the all-ones value of a w-bit counter (w < 64).
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] max_v;
        max_v = (64'd1 << w) - 64'd1;
        return (v >= max_v) ? max_v : v + 64'd1;
    endfunction

endpackage

// File: rtl/dff_golden_model.sv
// Reference model of a D flip-flop with a synchronous active-high clear.
// It is reusable by any checker that compares against a single flop.
module dff_golden_model (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic d_rst,
    input  logic load,
    output logic exp_q,
    output logic exp_valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q     <= 1'b0;
            exp_valid <= 1'b0;
        end else begin
            // The clear has priority over the data input.
            exp_q     <= d_rst ? 1'b0 : d;
            exp_valid <= load;
        end
    end

endmodule

// File: rtl/dff_resp_checker.sv
// Response checker for a D flip-flop: golden compare, sample/error counters, first-error capture.
// Optional build macro DFF_QBAR_CHECK_EN also flags samples where qbar is not the inverse of q.
module dff_resp_checker
    import dff_chk_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int NUM_SAMPLES = 10,
    parameter int STOP_ON_ERR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_en,
    input  logic             dut_d,
    input  logic             dut_rst,
    input  logic             dut_q,
    input  logic             dut_qbar,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             done,
    output logic [1:0]       state
);

    chk_state_t cur, nxt;
    logic       exp_q, exp_valid;
    logic       load, mismatch, cmp_en, last;

    assign state = cur;
    assign load  = (cur == ST_ARM) || (cur == ST_CHECK);

    dff_golden_model u_golden (
        .clk       (clk),
        .rst       (rst),
        .d         (dut_d),
        .d_rst     (dut_rst),
        .load      (load),
        .exp_q     (exp_q),
        .exp_valid (exp_valid)
    );

    // exp_q holds the value registered one edge earlier, matching the DUT's latency.
`ifdef DFF_QBAR_CHECK_EN
    assign mismatch = (dut_q != exp_q) || (dut_qbar != ~dut_q);
`else
    logic unused_qbar;
    assign unused_qbar = dut_qbar;
    assign mismatch    = (dut_q != exp_q);
`endif

    assign cmp_en = chk_en && (cur == ST_CHECK) && exp_valid && !done;
    assign last   = (NUM_SAMPLES > 0) && (64'(sample_cnt) + 64'd1 == 64'(NUM_SAMPLES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur <= ST_IDLE;
        else      cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        if (!chk_en) begin
            nxt = ST_IDLE;
        end else begin
            case (cur)
                ST_IDLE:  nxt = ST_ARM;
                ST_ARM:   nxt = ST_CHECK;
                ST_CHECK: if ((STOP_ON_ERR != 0) && cmp_en && mismatch) nxt = ST_FAIL;
                ST_FAIL:  nxt = ST_FAIL;
                default:  nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err           <= 1'b0;
            err_cnt       <= '0;
            sample_cnt    <= '0;
            first_err_idx <= '0;
            done          <= 1'b0;
        end else if (cur == ST_IDLE && chk_en) begin
            err           <= 1'b0;
            err_cnt       <= '0;
            sample_cnt    <= '0;
            first_err_idx <= '0;
            done          <= 1'b0;
        end else if (cmp_en) begin
            sample_cnt <= CNT_W'(sat_inc(64'(sample_cnt), CNT_W));
            if (mismatch) begin
                err     <= 1'b1;
                err_cnt <= CNT_W'(sat_inc(64'(err_cnt), CNT_W));
                // err is still clear only on the first mismatch of this run.
                if (!err) first_err_idx <= sample_cnt;
            end
            if (last) done <= 1'b1;
        end
    end

endmodule
